// File: rtl/sobel_pkg.sv
// Shared constants and arithmetic helpers for the Sobel edge pipeline.
// The line-buffer window block is also shared with the median filter.
package sobel_pkg;
    localparam int LATENCY = 4;
    localparam int PIX_W   = 8;
    localparam int GRAD_W  = 11;
    localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
    localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

    typedef logic [PIX_W-1:0] pix_t;

    // 1-2-1 weighted sum of three pixels; at most 1020, so it fits GRAD_W signed
    function automatic logic signed [GRAD_W-1:0] wsum(input pix_t a, input pix_t b, input pix_t c);
        logic signed [GRAD_W-1:0] ea, eb, ec;
        ea = $signed({{(GRAD_W-PIX_W){1'b0}}, a});
        eb = $signed({{(GRAD_W-PIX_W){1'b0}}, b});
        ec = $signed({{(GRAD_W-PIX_W){1'b0}}, c});
        return ea + (eb <<< 1) + ec;
    endfunction

    function automatic pix_t sat_pix(input logic [GRAD_W:0] m);
        return (|m[GRAD_W:PIX_W]) ? {PIX_W{1'b1}} : m[PIX_W-1:0];
    endfunction
endpackage

// File: rtl/sobel_matrix_3x3.sv
// Two line buffers plus col/row counters producing a registered 3x3 window.
// win_valid is low whenever the window still contains rows/cols from outside the frame.
module sobel_matrix_3x3
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = 640
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    input  logic href,
    input  pix_t pix,
    output pix_t win [3][3],
    output logic win_valid
);
    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [10:0] ROW_MAX = 11'd2047;

    logic [10:0]   col, row;
    logic          href_d;
    logic [AW-1:0] addr;
    pix_t          lb1 [IMG_WIDTH];
    pix_t          lb2 [IMG_WIDTH];
    pix_t          tap1, tap2;

    assign addr = col[AW-1:0];
    assign tap1 = lb1[addr];
    assign tap2 = lb2[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            href_d <= 1'b0;
        end else begin
            href_d <= href;
            col    <= href ? col + 11'd1 : '0;
            if (vsync)
                row <= '0;
            else if (href_d && !href && row != ROW_MAX)
                row <= row + 11'd1;
        end
    end

    // Buffer contents are never reset: the row/col mask hides anything stale.
    always_ff @(posedge clk) begin
        if (href) begin
            lb1[addr] <= pix;
            lb2[addr] <= tap1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= href && (row >= 11'd2) && (col >= 11'd2);
            if (href) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= tap2;
                win[1][2] <= tap1;
                win[2][2] <= pix;
            end
        end
    end
endmodule

// File: rtl/sobel_edge_detector.sv
// Sobel edge detector: window (stage 1), gradients (2), saturated magnitude (3),
// threshold compare (4), with vsync/href delayed to match.
module sobel_edge_detector
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic [7:0] per_img_y,
    input  logic [7:0] threshold,
    output logic       pos_frame_vsync,
    output logic       pos_frame_href,
    output logic [7:0] pos_img_y
);
    if (IMG_WIDTH < 2 || IMG_WIDTH > 2048 || IMG_HEIGHT < 3 || IMG_HEIGHT > 2048) begin : g_param_check
        $error("sobel_edge_detector: IMG_WIDTH/IMG_HEIGHT out of range");
    end

    pix_t                     win [3][3];
    logic                     win_valid;
    logic signed [GRAD_W-1:0] gx_c, gy_c, gx, gy;
    logic [GRAD_W-1:0]        abs_x, abs_y;
    logic [GRAD_W:0]          mag_c;
    pix_t                     mag_sat;
    logic                     valid2, valid3;
    logic [LATENCY-1:0]       vs_sr, hr_sr;

    sobel_matrix_3x3 #(.IMG_WIDTH(IMG_WIDTH)) u_matrix (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync     (per_frame_vsync),
        .href      (per_frame_href),
        .pix       (per_img_y),
        .win       (win),
        .win_valid (win_valid)
    );

    assign gx_c  = wsum(win[0][2], win[1][2], win[2][2]) - wsum(win[0][0], win[1][0], win[2][0]);
    assign gy_c  = wsum(win[2][0], win[2][1], win[2][2]) - wsum(win[0][0], win[0][1], win[0][2]);
    assign abs_x = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
    assign abs_y = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
    assign mag_c = {1'b0, abs_x} + {1'b0, abs_y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx        <= '0;
            gy        <= '0;
            valid2    <= 1'b0;
            mag_sat   <= '0;
            valid3    <= 1'b0;
            pos_img_y <= EDGE_OFF;
            vs_sr     <= '0;
            hr_sr     <= '0;
        end else begin
            gx        <= gx_c;
            gy        <= gy_c;
            valid2    <= win_valid;
            mag_sat   <= sat_pix(mag_c);
            valid3    <= valid2;
            pos_img_y <= (valid3 && (mag_sat > threshold)) ? EDGE_ON : EDGE_OFF;
            vs_sr     <= {vs_sr[LATENCY-2:0], per_frame_vsync};
            hr_sr     <= {hr_sr[LATENCY-2:0], per_frame_href};
        end
    end

    assign pos_frame_vsync = vs_sr[LATENCY-1];
    assign pos_frame_href  = hr_sr[LATENCY-1];
endmodule

// File: tb/tb_sobel_edge_detector.sv
// Scoreboard bench for sobel_edge_detector on a 16x8 image: a direct image-domain
// Sobel model predicts every output cycle, compared four cycles after the stimulus.
module tb_sobel_edge_detector;
    localparam int W = 16;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs, href;
    logic [7:0] pix, thr;
    logic       pos_vs, pos_href;
    logic [7:0] pos_y;

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic [7:0] y;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   passed = 0;
    int   total = 0;
    int   ff_cnt = 0;
    bit   chk_en = 1'b0;
    int   img [H][W];

    sobel_edge_detector #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (vs),
        .per_frame_href  (href),
        .per_img_y       (pix),
        .threshold       (thr),
        .pos_frame_vsync (pos_vs),
        .pos_frame_href  (pos_href),
        .pos_img_y       (pos_y)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_en && q.size() > 4) begin
            e = q.pop_front();
            total++;
            if (pos_vs !== e.vs) $display("FAIL vsync_delay: got %b expected %b at %0t", pos_vs, e.vs, $time);
            else passed++;
            total++;
            if (pos_href !== e.hr) $display("FAIL href_delay: got %b expected %b at %0t", pos_href, e.hr, $time);
            else passed++;
            total++;
            if (pos_y !== e.y) $display("FAIL pix_out: got %h expected %h at %0t", pos_y, e.y, $time);
            else passed++;
            if (pos_y === 8'hFF) ff_cnt++;
        end
    end

    function automatic logic [7:0] model_y(int r, int c, int t);
        int gx, gy, m;
        if (r < 2 || c < 2) return 8'h00;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        return (m > t) ? 8'hFF : 8'h00;
    endfunction

    task automatic step(input logic v, input logic h, input logic [7:0] p, input logic [7:0] ey);
        vs = v; href = h; pix = p;
        q.push_back('{vs: v, hr: h, y: ey});
        @(posedge clk); #1;
    endtask

    task automatic set_image(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c >= 8) ? 200 : 0;
                    default: img[r][c] = (r >= 4) ? 200 : 0;
                endcase
    endtask

    task automatic send_frame(input int t);
        thr = t[7:0];
        ff_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) step(1'b0, 1'b1, img[r][c][7:0], model_y(r, c, t));
            for (int g = 0; g < 4; g++) step(1'b0, 1'b0, 8'h00, 8'h00);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset;
        vs = 1'b1; href = 1'b0; pix = 8'h00; thr = 8'd40;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (pos_vs !== 1'b0) $display("FAIL reset_vsync: got %b expected 0", pos_vs); else passed++;
        total++; if (pos_href !== 1'b0) $display("FAIL reset_href: got %b expected 0", pos_href); else passed++;
        total++; if (pos_y !== 8'h00) $display("FAIL reset_pix: got %h expected 00", pos_y); else passed++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic test_uniform;
        set_image(0);
        send_frame(40);
        total++; if (ff_cnt !== 0) $display("FAIL uniform_edges: got %0d expected 0", ff_cnt); else passed++;
    endtask

    task automatic test_vstep;
        set_image(1);
        send_frame(40);
        total++; if (ff_cnt !== 12) $display("FAIL vstep_edges: got %0d expected 12", ff_cnt); else passed++;
    endtask

    task automatic test_hstep;
        set_image(2);
        send_frame(40);
        total++; if (ff_cnt !== 28) $display("FAIL hstep_edges: got %0d expected 28", ff_cnt); else passed++;
    endtask

    task automatic test_thr255;
        set_image(1);
        send_frame(255);
        total++; if (ff_cnt !== 0) $display("FAIL thr255_edges: got %0d expected 0", ff_cnt); else passed++;
    endtask

    task automatic test_sync_toggle;
        thr = 8'd0;
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'h00);
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 1'b0, 8'($urandom_range(0, 255)), 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid;
        set_image(1);
        thr = 8'd40;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < W; c++) step(1'b0, 1'b1, img[r][c][7:0], model_y(r, c, 40));
            for (int g = 0; g < 4; g++) step(1'b0, 1'b0, 8'h00, 8'h00);
        end
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1, img[4][c][7:0], model_y(4, c, 40));
        vs = 1'b0; href = 1'b1; pix = img[4][5][7:0];
        chk_en = 1'b0;
        q.delete();
        #2 rst_n = 1'b0;
        #1;
        total++; if (pos_href !== 1'b0) $display("FAIL midreset_href: got %b expected 0", pos_href); else passed++;
        total++; if (pos_vs !== 1'b0) $display("FAIL midreset_vsync: got %b expected 0", pos_vs); else passed++;
        total++; if (pos_y !== 8'h00) $display("FAIL midreset_pix: got %h expected 00", pos_y); else passed++;
        vs = 1'b1; href = 1'b0; pix = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        send_frame(40);
        total++; if (ff_cnt !== 12) $display("FAIL postreset_edges: got %0d expected 12", ff_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_vstep();
        test_hstep();
        test_thr255();
        test_sync_toggle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
